// File: rtl/adler32_stream.sv
// Adler-32 checksum engine: takes a byte count, then consumes a valid/ready
// stream of BYTES bytes per beat and pulses checksum_valid with {B, A}.
module adler32_stream #(
  parameter int unsigned BYTES = 1,
  parameter int unsigned LEN_W = 32,
  parameter int unsigned MOD   = 65521
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               size_valid,
  input  logic [LEN_W-1:0]   size,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  output logic               busy,
  output logic               checksum_valid,
  output logic [31:0]        checksum
);

  localparam int unsigned HALF_W = 16;
  localparam int unsigned SUM_W  = HALF_W + 1;
  localparam logic [SUM_W-1:0] MOD_S   = SUM_W'(MOD);
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   a_q, a_d;
  logic [HALF_W-1:0]   b_q, b_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                checksum_valid_q, checksum_valid_d;

  logic [HALF_W-1:0]   a_nxt, b_nxt;
  logic [SUM_W-1:0]    sum_a, sum_b;

  // Per-beat byte chain; only the first min(BYTES, rem) lanes take part.
  always_comb begin
    a_nxt = a_q;
    b_nxt = b_q;
    sum_a = '0;
    sum_b = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (LEN_W'(i) < rem_q) begin
        sum_a = {1'b0, a_nxt} + SUM_W'(in_data[8*i +: 8]);
        if (sum_a >= MOD_S) begin
          sum_a = sum_a - MOD_S;
        end
        a_nxt = sum_a[HALF_W-1:0];
        sum_b = {1'b0, b_nxt} + {1'b0, a_nxt};
        if (sum_b >= MOD_S) begin
          sum_b = sum_b - MOD_S;
        end
        b_nxt = sum_b[HALF_W-1:0];
      end
    end
  end

  // Next-state, accumulator and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (size_valid) begin
          rem_d   = size;
          a_d     = HALF_W'(1);
          b_d     = '0;
          state_d = (size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid && in_ready_q) begin
          a_d = a_nxt;
          b_d = b_nxt;
          if (rem_q <= BYTES_L) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d = rem_q - BYTES_L;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d       = (state_d == RUN);
    busy_d           = (state_d == RUN);
    checksum_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      a_q              <= HALF_W'(1);
      b_q              <= '0;
      rem_q            <= '0;
      in_ready_q       <= 1'b0;
      busy_q           <= 1'b0;
      checksum_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_q              <= a_d;
      b_q              <= b_d;
      rem_q            <= rem_d;
      in_ready_q       <= in_ready_d;
      busy_q           <= busy_d;
      checksum_valid_q <= checksum_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign checksum_valid = checksum_valid_q;
  assign checksum       = {b_q, a_q};

endmodule

// File: tb/tb_adler32_stream.sv
// Directed bench for adler32_stream at BYTES = 1, 2 and 4.
module tb_adler32_stream;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sv;
  logic [2:0]  iv;
  logic [31:0] sz;
  logic [31:0] din;
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [2:0]  cv;
  logic [31:0] ck [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] msg_q [$];

  adler32_stream #(.BYTES(1), .LEN_W(32), .MOD(65521)) u_b1 (
    .clk(clk), .rst_n(rst_n), .size_valid(sv[0]), .size(sz),
    .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(din[7:0]),
    .busy(bsy[0]), .checksum_valid(cv[0]), .checksum(ck[0])
  );

  adler32_stream #(.BYTES(2), .LEN_W(32), .MOD(65521)) u_b2 (
    .clk(clk), .rst_n(rst_n), .size_valid(sv[1]), .size(sz),
    .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(din[15:0]),
    .busy(bsy[1]), .checksum_valid(cv[1]), .checksum(ck[1])
  );

  adler32_stream #(.BYTES(4), .LEN_W(32), .MOD(65521)) u_b4 (
    .clk(clk), .rst_n(rst_n), .size_valid(sv[2]), .size(sz),
    .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(din),
    .busy(bsy[2]), .checksum_valid(cv[2]), .checksum(ck[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference Adler-32 of the first n message bytes.
  function automatic logic [31:0] adler_ref(input int n);
    int unsigned a;
    int unsigned b;
    a = 1;
    b = 0;
    for (int i = 0; i < n; i++) begin
      a = (a + 32'(msg_q[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_fill(input int n, input logic [7:0] v);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes pos.. of the message in lane order; lanes past the end carry garbage.
  task automatic drive_beat(input int pos, input int bw);
    din = $urandom();
    for (int j = 0; j < bw; j++) begin
      if (pos + j < msg_q.size()) din[8*j +: 8] = msg_q[pos + j];
    end
  endtask

  // Runs msg_q through instance k; optional 3-cycle stall and stray size_valid.
  task automatic run_msg(input int k, input int bw, input string tag,
                         input logic [31:0] exp_ck, input int stall_beat, input int sv_beat);
    int len;
    int pos;
    int beat;
    len  = msg_q.size();
    pos  = 0;
    beat = 0;
    sz    = 32'(len);
    sv[k] = 1'b1;
    tick();
    sv[k] = 1'b0;
    if (len == 0) begin
      check({tag, " zero cv"}, 32'(cv[k]), 32'd1);
      check({tag, " zero ck"}, ck[k], 32'h0000_0001);
      check({tag, " zero busy"}, 32'(bsy[k]), 32'd0);
    end else begin
      check({tag, " start ck"}, ck[k], 32'h0000_0001);
      check({tag, " start rdy"}, 32'(rdy[k]), 32'd1);
      while (pos < len) begin
        if (beat == stall_beat) begin
          iv[k] = 1'b0;
          din   = 32'hDEAD_BEEF;
          repeat (3) tick();
          check($sformatf("%s stall ck", tag), ck[k], adler_ref(pos));
          check($sformatf("%s stall rdy", tag), 32'(rdy[k]), 32'd1);
        end
        drive_beat(pos, bw);
        iv[k] = 1'b1;
        if (beat == sv_beat) begin
          sv[k] = 1'b1;
          sz    = 32'd5;
        end
        tick();
        iv[k] = 1'b0;
        sv[k] = 1'b0;
        pos  += bw;
        beat++;
        if (pos < len) begin
          check($sformatf("%s beat%0d ck", tag, beat), ck[k], adler_ref(pos));
          check($sformatf("%s beat%0d cv", tag, beat), 32'(cv[k]), 32'd0);
          check($sformatf("%s beat%0d rdy", tag, beat), 32'(rdy[k]), 32'd1);
        end
      end
      check({tag, " cv"}, 32'(cv[k]), 32'd1);
      check({tag, " ck"}, ck[k], exp_ck);
      check({tag, " rdy drop"}, 32'(rdy[k]), 32'd0);
      check({tag, " busy drop"}, 32'(bsy[k]), 32'd0);
    end
    tick();
    check({tag, " cv pulse"}, 32'(cv[k]), 32'd0);
    check({tag, " ck hold"}, ck[k], exp_ck);
  endtask

  initial begin
    rst_n = 1'b0;
    sv    = '0;
    iv    = '0;
    sz    = '0;
    din   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ck%0d", k), ck[k], 32'h0000_0001);
      check($sformatf("reset cv%0d", k), 32'(cv[k]), 32'd0);
      check($sformatf("reset rdy%0d", k), 32'(rdy[k]), 32'd0);
      check($sformatf("reset busy%0d", k), 32'(bsy[k]), 32'd0);
    end

    load_str("abc");
    run_msg(0, 1, "abc_b1", 32'h024D_0127, -1, -1);

    load_str("Wikipedia");
    run_msg(2, 4, "wiki_b4", 32'h11E6_0398, -1, -1);

    load_str("abcdefghijklmnopqrstuvwxyz");
    run_msg(1, 2, "az_b2", 32'h9086_0B20, 5, -1);

    load_fill(300, 8'hFF);
    run_msg(0, 1, "ff300_b1", 32'hB90F_2AE4, -1, -1);

    load_str("");
    run_msg(0, 1, "zero_b1", 32'h0000_0001, -1, -1);
    load_str("abc");
    run_msg(0, 1, "b2b_abc", 32'h024D_0127, -1, -1);

    // Reset after 2 of 9 bytes aborts the message silently.
    load_str("Wikipedia");
    sz    = 32'd9;
    sv[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drive_beat(p, 1);
      iv[0] = 1'b1;
      tick();
    end
    iv[0] = 1'b0;
    check("abort partial ck", ck[0], adler_ref(2));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 32'(bsy[0]), 32'd0);
    check("abort rdy", 32'(rdy[0]), 32'd0);
    check("abort ck", ck[0], 32'h0000_0001);
    iv[0] = 1'b1;
    din   = 32'h0000_0055;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort no cv %0d", c), 32'(cv[0]), 32'd0);
      tick();
    end
    iv[0] = 1'b0;
    check("idle in_valid ignored", ck[0], 32'h0000_0001);

    load_str("Wikipedia");
    run_msg(2, 4, "wiki_sv_busy", 32'h11E6_0398, -1, 1);
    load_str("abcdefghijklmnopqrstuvwxyz");
    run_msg(0, 1, "az_sv_busy", 32'h9086_0B20, -1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
